regfile_mp: RTL

Parametrised multi-port integer register file with an integrated busy-bit scoreboard and a post-reset clearing sequencer. It replaces the single-write, two-read register file between decode (read ports, busy set) and write-back (two write ports) for dual-issue configurations. Register 0 is hard-wired to zero. Same-cycle write-to-read bypass is supported for both data and busy status.

---
 rtl/regfile_mp.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with dual write-back ports, busy-bit scoreboard
// and a post-reset sequencer that zeroes every register before accepting traffic.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       set_en,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic                       flush,
  output logic                       init_done
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_init_done;
  logic                w_init_done_nxt;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic w_run;
  logic w_we0_ok;
  logic w_we1_ok;

  assign w_run    = (r_state == ST_RUN);
  assign w_we0_ok = we0 && (waddr0 != '0);
  assign w_we1_ok = we1 && (waddr1 != '0);

  // Clearing sequencer: one register per rdy-high edge, starting at x1.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_init_done_nxt = r_init_done;
    if (rdy && (r_state == ST_INIT)) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == '1) begin
        w_state_nxt     = ST_RUN;
        w_init_done_nxt = 1'b1;
      end
    end
  end

  // Busy update order: write clears, then flush or set (set beats a write-clear).
  always_comb begin
    w_busy_nxt = r_busy;
    if (rdy && w_run) begin
      if (w_we0_ok) w_busy_nxt[waddr0] = 1'b0;
      if (w_we1_ok) w_busy_nxt[waddr1] = 1'b0;
      if (flush) begin
        w_busy_nxt = '0;
      end else if (set_en && (set_addr != '0)) begin
        w_busy_nxt[set_addr] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= ADDR_W'(1);
      r_init_done <= 1'b0;
      r_busy      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= w_init_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Storage has no reset; the sequencer zeroes it. Port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (!w_run) begin
        r_regs[r_cnt] <= '0;
      end else begin
        if (w_we0_ok) r_regs[waddr0] <= wdata0;
        if (w_we1_ok) r_regs[waddr1] <= wdata1;
      end
    end
  end

  assign init_done = r_init_done;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_ra = raddr[k*ADDR_W +: ADDR_W];
    assign w_en = rst_n && rdy && w_run && re[k] && (w_ra != '0);

    // Bypass from the in-flight writes; a same-cycle set is not visible here.
    always_comb begin
      w_data = '0;
      w_bsy  = 1'b0;
      if (w_en) begin
        if (we1 && (waddr1 == w_ra)) begin
          w_data = wdata1;
        end else if (we0 && (waddr0 == w_ra)) begin
          w_data = wdata0;
        end else begin
          w_data = r_regs[w_ra];
          w_bsy  = r_busy[w_ra];
        end
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = w_data;
    assign rbusy[k]                  = w_bsy;
  end

endmodule
